// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory access controller: state and operation
// encodings plus the default geometry and latencies agreed with the control unit and DR.
package dm_pkg;

    localparam int DM_ADDR_W    = 12;
    localparam int DM_DATA_W    = 16;
    localparam int DM_MEM_DEPTH = 4096;
    localparam int DM_RD_LAT    = 2;
    localparam int DM_WR_LAT    = 1;
    localparam int DM_CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } dm_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } dm_op_e;

    // Latency counter preset for the operation in flight.
    function automatic logic [DM_CNT_W-1:0] lat_value(input dm_op_e op, input int rd_lat,
                                                      input int wr_lat);
        lat_value = (op == OP_WRITE) ? DM_CNT_W'(wr_lat) : DM_CNT_W'(rd_lat);
    endfunction

endpackage

// File: rtl/dm_lat_counter.sv
// Loadable 4-bit down-counter pacing the SRAM latency; load wins over decrement
// and the count never wraps below zero.
module dm_lat_counter
    import dm_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                i_load,
    input  logic                i_dec,
    input  logic [DM_CNT_W-1:0] i_value,
    output logic                o_zero,
    output logic                o_one
);

    logic [DM_CNT_W-1:0] r_count;

    // Count register: load, saturating decrement, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= DM_CNT_W'(0);
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_dec && (r_count != DM_CNT_W'(0))) begin
            r_count <= r_count - DM_CNT_W'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_zero = (r_count == DM_CNT_W'(0));
    assign o_one  = (r_count == DM_CNT_W'(1));

endmodule

// File: rtl/dm_access_ctrl.sv
// Data-memory access controller between the control unit / AR / DR and a
// fixed-latency synchronous SRAM port. All outputs come straight from flops.
module dm_access_ctrl
    import dm_pkg::*;
#(
    parameter int ADDR_W    = DM_ADDR_W,
    parameter int DATA_W    = DM_DATA_W,
    parameter int MEM_DEPTH = DM_MEM_DEPTH,
    parameter int RD_LAT    = DM_RD_LAT,
    parameter int WR_LAT    = DM_WR_LAT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_rd,
    input  logic              mem_wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [DATA_W-1:0] dr_data,
    output logic              dr_wr,
    output logic              sram_en,
    output logic              sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    // Depth is clamped to the address span so the bound fits one extra bit.
    localparam int              ADDR_SPAN = 1 << ADDR_W;
    localparam int              DEPTH_EFF = (MEM_DEPTH < ADDR_SPAN) ? MEM_DEPTH : ADDR_SPAN;
    localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(DEPTH_EFF);

    dm_state_e            r_state;
    dm_state_e            w_state_nxt;
    dm_op_e               r_op;
    dm_op_e               w_op_in;
    logic                 w_addr_ok;
    logic                 w_accept;
    logic                 w_reject;
    logic                 w_capture;
    logic                 w_cnt_load;
    logic                 w_cnt_dec;
    logic [DM_CNT_W-1:0]  w_cnt_value;
    logic                 w_cnt_zero;
    logic                 w_cnt_one;

    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic                 r_dr_wr;
    logic                 r_sram_en;
    logic                 r_sram_we;
    logic [DATA_W-1:0]    r_dr_data;
    logic [ADDR_W-1:0]    r_sram_addr;
    logic [DATA_W-1:0]    r_sram_wdata;

    assign w_addr_ok   = ({1'b0, addr} < DEPTH_LIM);
    assign w_op_in     = mem_wr ? OP_WRITE : OP_READ;
    assign w_cnt_value = lat_value(r_op, RD_LAT, WR_LAT);

    dm_lat_counter u_lat_counter (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_cnt_load),
        .i_dec   (w_cnt_dec),
        .i_value (w_cnt_value),
        .o_zero  (w_cnt_zero),
        .o_one   (w_cnt_one)
    );

    // Next-state and control decode; commands are only looked at in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_reject    = 1'b0;
        w_capture   = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_rd && mem_wr) begin
                    w_reject = 1'b1;
                end else if ((mem_rd || mem_wr) && !w_addr_ok) begin
                    w_reject = 1'b1;
                end else if (mem_rd || mem_wr) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                w_cnt_load = 1'b1;
                if (w_cnt_value == DM_CNT_W'(0)) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_cnt_dec = 1'b1;
                // Zero is unreachable here but is treated as expiry rather than wrapping.
                if (w_cnt_one || w_cnt_zero) begin
                    w_state_nxt = ST_DONE;
                    w_capture   = (r_op == OP_READ);
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, op and all output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_op         <= OP_READ;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_dr_wr      <= 1'b0;
            r_sram_en    <= 1'b0;
            r_sram_we    <= 1'b0;
            r_dr_data    <= DATA_W'(0);
            r_sram_addr  <= ADDR_W'(0);
            r_sram_wdata <= DATA_W'(0);
        end else begin
            r_state   <= w_state_nxt;
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= (w_state_nxt == ST_DONE);
            r_dr_wr   <= (w_state_nxt == ST_DONE) && (r_op == OP_READ);
            r_err     <= w_reject;
            r_sram_en <= w_accept;
            r_sram_we <= w_accept && (w_op_in == OP_WRITE);
            if (w_accept) begin
                r_op        <= w_op_in;
                r_sram_addr <= addr;
            end
            if (w_accept && (w_op_in == OP_WRITE)) begin
                r_sram_wdata <= wdata;
            end
            if (w_capture) begin
                r_dr_data <= sram_rdata;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign dr_wr      = r_dr_wr;
    assign dr_data    = r_dr_data;
    assign sram_en    = r_sram_en;
    assign sram_we    = r_sram_we;
    assign sram_addr  = r_sram_addr;
    assign sram_wdata = r_sram_wdata;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl: directed scenarios, reset behaviour and
// randomized windows checked against a transaction-level timeline model.
`timescale 1ns/1ps
module tb_dm_access_ctrl;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 3000;
    localparam int RD_LAT = 2;
    localparam int WR_LAT = 1;
    localparam int NMAX   = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              mem_rd = 1'b0;
    logic              mem_wr = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic              busy, done, err, dr_wr, sram_en, sram_we;
    logic [DATA_W-1:0] dr_data, sram_wdata, sram_rdata;
    logic [ADDR_W-1:0] sram_addr;

    int vec_cnt = 0;
    int err_cnt = 0;

    dm_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH),
                     .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
        .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .dr_data(dr_data), .dr_wr(dr_wr),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input logic [11:0] a);
        return (16'(a) * 16'h9E37) ^ 16'hA5C3;
    endfunction

    // Pin-level SRAM: data of a read issued in cycle 1 appears in cycle 1+RD_LAT.
    logic [15:0] sram_mem [0:4095];
    bit          sram_written [0:4095];
    logic [15:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        if (sram_en === 1'b1 && sram_we === 1'b1) begin
            sram_mem[sram_addr]     <= sram_wdata;
            sram_written[sram_addr] <= 1'b1;
        end
        if (sram_en === 1'b1 && sram_we === 1'b0)
            rd_pipe[0] <= sram_written[sram_addr] ? sram_mem[sram_addr] : init_word(sram_addr);
        else
            rd_pipe[0] <= 16'($urandom);
        for (int k = 1; k < RD_LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
    end
    assign sram_rdata = rd_pipe[RD_LAT-1];

    // Reference state
    logic [15:0] ref_mem [int];
    logic [15:0] ref_dr_data, ref_sram_wdata;
    logic [11:0] ref_sram_addr;

    function automatic logic [15:0] ref_read(input logic [11:0] a);
        if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
        return init_word(a);
    endfunction

    logic        stim_rd [NMAX];
    logic        stim_wr [NMAX];
    logic [11:0] stim_addr [NMAX];
    logic [15:0] stim_wdata [NMAX];
    logic [5:0]  obs_ctrl [NMAX];
    logic [5:0]  exp_ctrl [NMAX];
    logic [15:0] obs_drd [NMAX];
    logic [15:0] exp_drd [NMAX];
    logic [11:0] obs_addr [NMAX];
    logic [11:0] exp_addr [NMAX];
    logic [15:0] obs_wd [NMAX];
    logic [15:0] exp_wd [NMAX];

    task automatic clear_stim();
        for (int c = 0; c < NMAX; c++) begin
            stim_rd[c] = 1'b0; stim_wr[c] = 1'b0; stim_addr[c] = 12'h000; stim_wdata[c] = 16'h0000;
        end
    endtask

    // Cycle c stimulus is applied just after the edge that starts cycle c; outputs sampled mid-cycle.
    task automatic run_window(input int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk); #1;
            mem_rd = stim_rd[c]; mem_wr = stim_wr[c]; addr = stim_addr[c]; wdata = stim_wdata[c];
            @(negedge clk);
            obs_ctrl[c] = {busy, done, err, dr_wr, sram_en, sram_we};
            obs_drd[c] = dr_data; obs_addr[c] = sram_addr; obs_wd[c] = sram_wdata;
        end
        mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    // Timeline model. ctrl bits are {busy, done, err, dr_wr, sram_en, sram_we}.
    task automatic build_expect(input int n);
        int free_at;
        int lat;
        logic [15:0] rv;
        free_at = 0;
        for (int j = 0; j < n; j++) begin
            exp_ctrl[j] = 6'b0; exp_drd[j] = ref_dr_data; exp_addr[j] = ref_sram_addr; exp_wd[j] = ref_sram_wdata;
        end
        for (int c = 0; c < n - 1; c++) begin
            if (c >= free_at && (stim_rd[c] || stim_wr[c])) begin
                if ((stim_rd[c] && stim_wr[c]) || int'(stim_addr[c]) >= DEPTH) begin
                    exp_ctrl[c+1][3] = 1'b1;
                end else begin
                    lat = stim_rd[c] ? RD_LAT + 2 : WR_LAT + 2;
                    exp_ctrl[c+1][1] = 1'b1;
                    exp_ctrl[c+1][0] = stim_wr[c];
                    for (int k = 1; k <= lat && c + k < n; k++) exp_ctrl[c+k][5] = 1'b1;
                    if (c + lat < n) begin
                        exp_ctrl[c+lat][4] = 1'b1;
                        exp_ctrl[c+lat][2] = stim_rd[c];
                    end
                    ref_sram_addr = stim_addr[c];
                    for (int j = c + 1; j < n; j++) exp_addr[j] = stim_addr[c];
                    if (stim_wr[c]) begin
                        ref_mem[int'(stim_addr[c])] = stim_wdata[c];
                        ref_sram_wdata = stim_wdata[c];
                        for (int j = c + 1; j < n; j++) exp_wd[j] = stim_wdata[c];
                    end else begin
                        rv = ref_read(stim_addr[c]);
                        ref_dr_data = rv;
                        for (int j = c + lat; j < n; j++) exp_drd[j] = rv;
                    end
                    free_at = c + lat + 1;
                end
            end
        end
    endtask

    task automatic test_reset();
        ref_dr_data = 16'h0; ref_sram_addr = 12'h0; ref_sram_wdata = 16'h0;
        #2 rst = 1'b1;
        #1;
        vec_cnt++;
        if ({busy, done, err, dr_wr, sram_en, sram_we, dr_data, sram_addr, sram_wdata} !== 60'h0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got ctrl=%b dr_data=%h sram_addr=%h sram_wdata=%h, want all zero",
                     {busy, done, err, dr_wr, sram_en, sram_we}, dr_data, sram_addr, sram_wdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed();
        string name;
        for (int s = 0; s < 11; s++) begin
            clear_stim();
            case (s)
                0: name = "idle";
                1: begin name = "write_beef"; stim_wr[0] = 1'b1; stim_addr[0] = 12'h123; stim_wdata[0] = 16'hBEEF; end
                2: begin name = "read_123"; stim_rd[0] = 1'b1; stim_addr[0] = 12'h123; end
                3: begin name = "write_0ff"; stim_wr[0] = 1'b1; stim_addr[0] = 12'h0FF; stim_wdata[0] = 16'h1234; end
                4: begin name = "read_0ff"; stim_rd[0] = 1'b1; stim_addr[0] = 12'h0FF; end
                5: begin name = "rd_and_wr"; stim_rd[0] = 1'b1; stim_wr[0] = 1'b1; stim_addr[0] = 12'h010; end
                6: begin name = "addr_depth"; stim_rd[0] = 1'b1; stim_addr[0] = 12'(DEPTH); end
                7: begin name = "addr_last"; stim_rd[0] = 1'b1; stim_addr[0] = 12'(DEPTH - 1); end
                8: begin name = "busy_ignore"; stim_rd[0] = 1'b1; stim_addr[0] = 12'h0FF;
                          stim_wr[2] = 1'b1; stim_addr[2] = 12'h0FF; stim_wdata[2] = 16'hDEAD; end
                9: begin name = "b2b_read";
                          for (int c = 0; c < 6; c++) begin
                              stim_rd[c] = 1'b1; stim_addr[c] = (c < 5) ? 12'h123 : 12'h0FF;
                          end
                   end
                10: begin name = "b2b_write";
                          for (int c = 0; c < 5; c++) begin
                              stim_wr[c] = 1'b1; stim_addr[c] = (c < 4) ? 12'h010 : 12'h011;
                              stim_wdata[c] = (c < 4) ? 16'hAAAA : 16'h5555;
                          end
                    end
                default: name = "none";
            endcase
            build_expect(12);
            run_window(12);
            for (int c = 0; c < 12; c++) begin
                vec_cnt += 4;
                if (obs_ctrl[c] !== exp_ctrl[c]) begin err_cnt++;
                    $display("FAIL %s ctrl c%0d: got %b want %b (busy,done,err,dr_wr,en,we)", name, c, obs_ctrl[c], exp_ctrl[c]); end
                if (obs_drd[c] !== exp_drd[c]) begin err_cnt++;
                    $display("FAIL %s dr_data c%0d: got %h want %h", name, c, obs_drd[c], exp_drd[c]); end
                if (obs_addr[c] !== exp_addr[c]) begin err_cnt++;
                    $display("FAIL %s sram_addr c%0d: got %h want %h", name, c, obs_addr[c], exp_addr[c]); end
                if (obs_wd[c] !== exp_wd[c]) begin err_cnt++;
                    $display("FAIL %s sram_wdata c%0d: got %h want %h", name, c, obs_wd[c], exp_wd[c]); end
            end
            if (s == 2 || s == 4) begin
                vec_cnt++;
                if (obs_drd[4] !== ((s == 2) ? 16'hBEEF : 16'h1234) || obs_ctrl[4][4] !== 1'b1 ||
                    obs_ctrl[4][2] !== 1'b1 || obs_ctrl[1][1:0] !== 2'b10) begin
                    err_cnt++;
                    $display("FAIL %s fixed_check: got dr_data=%h c4=%b c1=%b, want data %h with done,dr_wr in c4 and en only in c1",
                             name, obs_drd[4], obs_ctrl[4], obs_ctrl[1], (s == 2) ? 16'hBEEF : 16'h1234);
                end
            end
            if (s == 3) begin
                vec_cnt++;
                if (obs_wd[1] !== 16'h1234 || obs_ctrl[1][1:0] !== 2'b11 || obs_ctrl[3][4] !== 1'b1 || obs_ctrl[3][2] !== 1'b0) begin
                    err_cnt++;
                    $display("FAIL %s fixed_check: got wdata=%h c1=%b c3=%b, want 1234 with en,we in c1 and done without dr_wr in c3",
                             name, obs_wd[1], obs_ctrl[1], obs_ctrl[3]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_read();
        @(posedge clk); #1; mem_rd = 1'b1; addr = 12'h0FF;
        @(posedge clk); #1; mem_rd = 1'b0;
        @(posedge clk); #4; rst = 1'b1;
        #1;
        vec_cnt++;
        if ({busy, done, err, dr_wr, sram_en, sram_we, dr_data, sram_addr, sram_wdata} !== 60'h0) begin
            err_cnt++;
            $display("FAIL reset_mid_read: got ctrl=%b dr_data=%h sram_addr=%h sram_wdata=%h, want all zero",
                     {busy, done, err, dr_wr, sram_en, sram_we}, dr_data, sram_addr, sram_wdata);
        end
        @(posedge clk); @(negedge clk); rst = 1'b0;
        ref_dr_data = 16'h0; ref_sram_addr = 12'h0; ref_sram_wdata = 16'h0;
        for (int pass = 0; pass < 2; pass++) begin
            clear_stim();
            if (pass == 1) begin stim_rd[0] = 1'b1; stim_addr[0] = 12'h0FF; end
            build_expect(8);
            run_window(8);
            for (int c = 0; c < 8; c++) begin
                vec_cnt += 2;
                if (obs_ctrl[c] !== exp_ctrl[c]) begin err_cnt++;
                    $display("FAIL after_reset%0d ctrl c%0d: got %b want %b", pass, c, obs_ctrl[c], exp_ctrl[c]); end
                if (obs_drd[c] !== exp_drd[c]) begin err_cnt++;
                    $display("FAIL after_reset%0d dr_data c%0d: got %h want %h", pass, c, obs_drd[c], exp_drd[c]); end
            end
        end
        vec_cnt++;
        if (obs_drd[4] !== 16'h1234) begin err_cnt++;
            $display("FAIL fresh_read: got dr_data=%h want 1234", obs_drd[4]); end
    endtask

    task automatic test_random();
        int kind;
        for (int w = 0; w < 60; w++) begin
            clear_stim();
            kind = $urandom_range(0, 9);
            stim_addr[0]  = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, DEPTH - 1)) : 12'($urandom_range(0, 15));
            stim_wdata[0] = 16'($urandom);
            case (kind)
                0, 1, 2, 3: stim_rd[0] = 1'b1;
                4, 5, 6:    stim_wr[0] = 1'b1;
                7: begin stim_rd[0] = 1'b1; stim_wr[0] = 1'b1; end
                8: begin stim_rd[0] = 1'b1; stim_addr[0] = 12'($urandom_range(DEPTH, 4095)); end
                9: begin
                    stim_rd[0] = 1'b1;
                    stim_wr[$urandom_range(1, 4)] = 1'b1;
                   end
                default: stim_rd[0] = 1'b0;
            endcase
            build_expect(10);
            run_window(10);
            for (int c = 0; c < 10; c++) begin
                vec_cnt += 4;
                if (obs_ctrl[c] !== exp_ctrl[c]) begin err_cnt++;
                    $display("FAIL rand%0d ctrl c%0d: got %b want %b", w, c, obs_ctrl[c], exp_ctrl[c]); end
                if (obs_drd[c] !== exp_drd[c]) begin err_cnt++;
                    $display("FAIL rand%0d dr_data c%0d: got %h want %h", w, c, obs_drd[c], exp_drd[c]); end
                if (obs_addr[c] !== exp_addr[c]) begin err_cnt++;
                    $display("FAIL rand%0d sram_addr c%0d: got %h want %h", w, c, obs_addr[c], exp_addr[c]); end
                if (obs_wd[c] !== exp_wd[c]) begin err_cnt++;
                    $display("FAIL rand%0d sram_wdata c%0d: got %h want %h", w, c, obs_wd[c], exp_wd[c]); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_read();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/dm_access_ctrl.md
Name: dm_access_ctrl

Overview:
Data-memory access controller sitting directly upstream of the data register (DR).
- Takes read/write commands from the control unit with an address from AR.
- Sequences a fixed-latency synchronous SRAM port.
- On reads, delivers the returned word to DR via a one-cycle write strobe matching DR's WR input. On writes, sources the store data from DR's DM output.
- One instance per core.

Parameters:
ADDR_W, 12, address width (word-addressed)
DATA_W, 16, data width; matches DR and bus width
MEM_DEPTH, 4096, valid words; addresses >= MEM_DEPTH are rejected
RD_LAT, 2, SRAM read latency in cycles (legal 1..15)
WR_LAT, 1, extra SRAM write-settle cycles (legal 0..15)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
mem_rd  in  1  read command, sampled only in IDLE
mem_wr  in  1  write command, sampled only in IDLE
addr  in  ADDR_W  access address (from AR)
wdata  in  DATA_W  store data (from DR DM output)
busy  out  1  high from the cycle after acceptance through DONE inclusive
done  out  1  one-cycle completion pulse
err  out  1  one-cycle pulse on a rejected command
dr_data  out  DATA_W  read data to DR BIN path
dr_wr  out  1  one-cycle strobe to DR WR; high only in read DONE
sram_en  out  1  SRAM enable, one cycle per access
sram_we  out  1  SRAM write enable, coincident with sram_en
sram_addr  out  ADDR_W  latched address
sram_wdata  out  DATA_W  latched store data
sram_rdata  in  DATA_W  SRAM read data

Behaviour:
- Reset (async, any state):
  - State goes to IDLE and counter to 0.
  - busy, done, err, dr_wr, sram_en and sram_we go to 0.
  - dr_data, sram_addr and sram_wdata go to 0.
  - An in-flight access is aborted with no done pulse.
- States:
  - IDLE, ISSUE, WAIT and DONE.
  - Encoding: IDLE=0, ISSUE=1, WAIT=2, DONE=3.
  - One op bit records read or write.
- IDLE, with the request seen in cycle 0:
  - mem_rd XOR mem_wr with addr < MEM_DEPTH: latch addr (and wdata if writing) and the op, then go to ISSUE.
  - mem_rd and mem_wr both high, or addr >= MEM_DEPTH: err=1 in cycle 1, no SRAM activity, stay in IDLE.
  - Neither high: stay in IDLE.
- ISSUE (cycle 1):
  - sram_en=1; sram_we=1 for a write.
  - Counter loads RD_LAT for a read or WR_LAT for a write.
  - If the loaded value is 0, go to DONE; otherwise go to WAIT.
- WAIT:
  - Counter decrements each cycle; go to DONE when it reaches 1.
  - For a read, dr_data <= sram_rdata on the edge leaving WAIT. SRAM data is valid in cycle 1+RD_LAT.
- DONE:
  - done=1.
  - For a read, dr_wr=1 with dr_data stable; DR captures it at the end of DONE.
  - Go to IDLE.
- Latency:
  - Read: done/dr_wr in cycle RD_LAT+2 (cycle 4 at the default).
  - Write: done in cycle WR_LAT+2 (cycle 3 at the default).
- Commands while busy are ignored, not queued. A command held high through DONE is re-accepted in the following IDLE cycle.
- Back-to-back access: the next command may be presented in the cycle after DONE.
- dr_data holds its last read value until the next read completes; writes do not alter it.
- sram_addr and sram_wdata hold their latched values after completion.
- Registered outputs only: no combinational path from inputs to outputs.

Decomposition:
- Shared package dm_pkg: state encoding constants, the DATA_W default and the RD_LAT/WR_LAT defaults, so the control unit and DR agree.
- One sub-module, dm_lat_counter: a 4-bit loadable down-counter with load, dec and a zero/one flag. The FSM stays in dm_access_ctrl.

Test Plan:
- Reset then idle: assert rst mid-cycle -> all outputs 0 immediately. Hold mem_rd=mem_wr=0 for 10 cycles -> no sram_en.
- Read at addr=0x123, SRAM model returns 0xBEEF (RD_LAT=2):
  - sram_en=1, sram_we=0 in cycle 1 with sram_addr=0x123.
  - In cycle 4: dr_data=0xBEEF, dr_wr=1, done=1.
  - busy is high in cycles 1-4.
- Write at addr=0x0FF, wdata=0x1234 (WR_LAT=1):
  - sram_en=sram_we=1 in cycle 1 with sram_wdata=0x1234.
  - done=1 in cycle 3; dr_wr stays 0.
  - A subsequent read of 0x0FF yields 0x1234.
- Rejected commands:
  - mem_rd=mem_wr=1 -> err=1 in cycle 1, no sram_en, busy stays 0.
  - addr=MEM_DEPTH with mem_rd -> same response.
- Busy ignore: issue a read, pulse mem_wr in cycle 2 -> no second access, exactly one done.
- Reset mid-read: assert rst in cycle 2 of a read -> state IDLE, no done/dr_wr. A fresh read after release completes normally.
